// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch/decode handshake bundle for if_id_queue.
// IFID_PC_CHECK_EN adds the out_exc fault flag.
interface if_id_queue_if;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic        flush;
    logic [1:0]  count;
`ifdef IFID_PC_CHECK_EN
    logic        out_exc;
    modport master (output in_valid, in_pc, in_instr, out_ready, flush,
                    input in_ready, out_valid, out_pc, out_instr, count, out_exc);
    modport slave  (input in_valid, in_pc, in_instr, out_ready, flush,
                    output in_ready, out_valid, out_pc, out_instr, count, out_exc);
`else
    modport master (output in_valid, in_pc, in_instr, out_ready, flush,
                    input in_ready, out_valid, out_pc, out_instr, count);
    modport slave  (input in_valid, in_pc, in_instr, out_ready, flush,
                    output in_ready, out_valid, out_pc, out_instr, count);
`endif
endinterface

// File: rtl/if_id_queue.sv
// if_id_queue: two-entry IF->ID skid FIFO with flush; in_ready depends on registered count only.
// IFID_PC_CHECK_EN stores a PC-fault bit per entry and drives out_exc.
module if_id_queue #(
    parameter int          DEPTH   = 2,
    parameter logic [31:0] INIT_PC = 32'h0000_3000
) (
    input logic          clk,
    input logic          reset,
    if_id_queue_if.slave q
);
`ifdef IFID_PC_CHECK_EN
    localparam int W = 65;
`else
    localparam int W = 64;
`endif
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] din, head;
    logic         wr_ptr, rd_ptr, push, pop, in_ready, out_valid;
    logic [1:0]   count;
    assign in_ready  = count != 2'd2;
    assign out_valid = count != 2'd0;
    assign push      = q.in_valid & in_ready;
    assign pop       = out_valid & q.out_ready & ~q.flush;
    assign head      = mem[rd_ptr];
`ifdef IFID_PC_CHECK_EN
    logic exc;
    assign exc       = (q.in_pc[1:0] != 2'b00) | (q.in_pc < 32'h0000_3000) | (q.in_pc > 32'h0000_6FFF);
    // faulting fetches become nops but keep their PC for the exception handler
    assign din       = {exc, exc ? 32'h0 : q.in_instr, q.in_pc};
    assign q.out_exc = out_valid & head[64];
`else
    assign din       = {q.in_instr, q.in_pc};
`endif
    assign q.in_ready  = in_ready;
    assign q.out_valid = out_valid;
    assign q.out_pc    = out_valid ? head[31:0] : INIT_PC;
    assign q.out_instr = out_valid ? head[63:32] : 32'h0;
    assign q.count     = count;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (q.flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: table-driven directed bench for if_id_queue plus hand-written reset/flush/exc sequences.
module tb_if_id_queue;
    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic [1:0]  ec;
        logic        ev;
        logic        er;
        logic [31:0] epc;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t v [$];

    if_id_queue_if q ();
    if_id_queue dut (.clk(clk), .reset(reset), .q(q));

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return {pc[15:0], 16'hC0DE};
    endfunction

    function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl,
                                input logic [1:0] ec, input logic [31:0] epc);
        vec_t r;
        r.iv = iv; r.pc = pc; r.ordy = ordy; r.fl = fl;
        r.ec = ec; r.ev = ec != 2'd0; r.er = ec != 2'd2; r.epc = epc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
        q.in_valid = iv; q.in_pc = pc; q.in_instr = ins(pc); q.out_ready = ordy; q.flush = fl;
    endtask

    task automatic check_state(input string tag, input logic [1:0] ec, input logic [31:0] epc);
        chk({tag, " count"}, 32'(q.count), 32'(ec));
        chk({tag, " out_valid"}, 32'(q.out_valid), 32'(ec != 2'd0));
        chk({tag, " in_ready"}, 32'(q.in_ready), 32'(ec != 2'd2));
        chk({tag, " out_pc"}, q.out_pc, ec != 2'd0 ? epc : 32'h3000);
        chk({tag, " out_instr"}, q.out_instr, ec != 2'd0 ? ins(epc) : 32'h0);
    endtask

    task automatic apply(input vec_t t, input string tag);
        @(negedge clk);
        drive(t.iv, t.pc, t.ordy, t.fl);
        @(posedge clk);
        #1;
        check_state(tag, t.ec, t.epc);
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        #1 check_state("reset", 2'd0, 32'h3000);
        @(negedge clk) reset = 1'b1;

        // streaming at full rate
        v.push_back(mk(1, 32'h3000, 1, 0, 2'd1, 32'h3000));
        v.push_back(mk(1, 32'h3004, 1, 0, 2'd1, 32'h3004));
        v.push_back(mk(1, 32'h3008, 1, 0, 2'd1, 32'h3008));
        v.push_back(mk(0, 32'h0,    1, 0, 2'd0, 32'h3000));
        // decode stall fills the queue; 0x3008 is refused
        v.push_back(mk(1, 32'h3000, 0, 0, 2'd1, 32'h3000));
        v.push_back(mk(1, 32'h3004, 0, 0, 2'd2, 32'h3000));
        v.push_back(mk(1, 32'h3008, 0, 0, 2'd2, 32'h3000));
        v.push_back(mk(1, 32'h3008, 1, 0, 2'd1, 32'h3004));
        v.push_back(mk(0, 32'h0,    1, 0, 2'd0, 32'h3000));
        // flush at full with a concurrent fetch, then flush beating a push at count=1
        v.push_back(mk(1, 32'h3000, 0, 0, 2'd1, 32'h3000));
        v.push_back(mk(1, 32'h3004, 0, 0, 2'd2, 32'h3000));
        v.push_back(mk(1, 32'h3010, 1, 1, 2'd0, 32'h3000));
        v.push_back(mk(1, 32'h3020, 0, 0, 2'd1, 32'h3020));
        v.push_back(mk(1, 32'h3024, 1, 1, 2'd0, 32'h3000));
        v.push_back(mk(1, 32'h4000, 0, 0, 2'd1, 32'h4000));
        v.push_back(mk(0, 32'h0,    1, 0, 2'd0, 32'h3000));
        // simultaneous push/pop at count=1 across pointer wraps
        v.push_back(mk(1, 32'h3008, 0, 0, 2'd1, 32'h3008));
        v.push_back(mk(1, 32'h300C, 1, 0, 2'd1, 32'h300C));
        v.push_back(mk(1, 32'h3010, 1, 0, 2'd1, 32'h3010));
        v.push_back(mk(1, 32'h3014, 1, 0, 2'd1, 32'h3014));
        v.push_back(mk(1, 32'h3018, 1, 0, 2'd1, 32'h3018));
        v.push_back(mk(1, 32'h301C, 1, 0, 2'd1, 32'h301C));
        v.push_back(mk(0, 32'h0,    1, 0, 2'd0, 32'h3000));
        foreach (v[i]) apply(v[i], $sformatf("vec%0d", i));

        // flush cycle still shows the pre-flush head
        apply(mk(1, 32'h3200, 0, 0, 2'd1, 32'h3200), "pre_flush");
        @(negedge clk);
        drive(1'b1, 32'h3204, 1'b1, 1'b1);
        #1;
        chk("flush_cycle out_pc", q.out_pc, 32'h3200);
        chk("flush_cycle out_valid", 32'(q.out_valid), 32'd1);
        @(posedge clk);
        #1 check_state("post_flush", 2'd0, 32'h3000);

        // full queue: in_ready ignores out_ready; then async reset mid-stream
        apply(mk(1, 32'h3300, 0, 0, 2'd1, 32'h3300), "fill1");
        apply(mk(1, 32'h3304, 0, 0, 2'd2, 32'h3300), "fill2");
        q.out_ready = 1'b1; q.in_valid = 1'b0;
        #1 chk("full in_ready w/ out_ready", 32'(q.in_ready), 32'd0);
        #1 reset = 1'b0;
        #1 check_state("async_reset", 2'd0, 32'h3000);
        repeat (2) @(posedge clk);
        #1 check_state("reset_held", 2'd0, 32'h3000);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 32'h3100, 1'b0, 1'b0);
        @(posedge clk);
        #1 check_state("first_push", 2'd1, 32'h3100);
        apply(mk(0, 32'h0, 1, 0, 2'd0, 32'h3000), "drain");

`ifdef IFID_PC_CHECK_EN
        chk("exc empty", 32'(q.out_exc), 32'd0);
        @(negedge clk) drive(1'b1, 32'h3002, 1'b0, 1'b0);
        @(posedge clk) #1;
        chk("exc misaligned", 32'(q.out_exc), 32'd1);
        chk("exc misaligned instr", q.out_instr, 32'h0);
        chk("exc misaligned pc", q.out_pc, 32'h3002);
        @(negedge clk) drive(1'b1, 32'h7000, 1'b0, 1'b0);
        @(posedge clk) #1;
        chk("exc count", 32'(q.count), 32'd2);
        @(negedge clk) drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(posedge clk) #1;
        chk("exc high", 32'(q.out_exc), 32'd1);
        chk("exc high instr", q.out_instr, 32'h0);
        chk("exc high pc", q.out_pc, 32'h7000);
        @(negedge clk) drive(1'b1, 32'h3004, 1'b1, 1'b0);
        @(posedge clk) #1;
        chk("exc ok", 32'(q.out_exc), 32'd0);
        chk("exc ok instr", q.out_instr, ins(32'h3004));
        @(negedge clk) drive(1'b1, 32'h2FFC, 1'b1, 1'b0);
        @(posedge clk) #1;
        chk("exc low", 32'(q.out_exc), 32'd1);
        @(negedge clk) drive(1'b1, 32'h6FFC, 1'b1, 1'b0);
        @(posedge clk) #1;
        chk("exc top ok", 32'(q.out_exc), 32'd0);
        chk("exc top ok instr", q.out_instr, ins(32'h6FFC));
        @(negedge clk) drive(1'b0, 32'h0, 1'b1, 1'b1);
        @(posedge clk) #1;
        chk("exc after flush", 32'(q.out_exc), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
